// File: rtl/if_id_issue_buf.sv
// Dual-issue IF->ID instruction buffer: 4-entry circular queue that takes up to two
// fetched instructions per cycle and presents the two oldest to decode slots 0 and 1.

module if_id_issue_buf_chk (
   input logic       clk,
   input logic       rst_n,
   input logic [1:0] deq,
   input logic [2:0] count
);

   // Occupancy must stay within 0..4 and decode may never retire more than is held
   assert property (@(posedge clk) disable iff (!rst_n) ({1'b0, deq} <= count))
      else $error("issue buffer dequeue exceeds occupancy");
   assert property (@(posedge clk) disable iff (!rst_n) (count <= 3'd4))
      else $error("issue buffer occupancy above 4");

endmodule

module if_id_issue_buf #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            If_Valid,
   input  logic [ADDR_WIDTH-1:0] If_PC0,
   input  logic [ADDR_WIDTH-1:0] If_PC1,
   input  logic [INST_WIDTH-1:0] If_Inst0,
   input  logic [INST_WIDTH-1:0] If_Inst1,
   output logic                  If_Ready,
   input  logic [4:0]            Ctrl_Stall,
   input  logic [3:0]            Flush,
   input  logic                  EX_BranchFlag,
   input  logic [1:0]            Id_Accept,
   output logic [1:0]            Id_Valid,
   output logic [ADDR_WIDTH-1:0] Id_PC0,
   output logic [ADDR_WIDTH-1:0] Id_PC1,
   output logic [INST_WIDTH-1:0] Id_Inst0,
   output logic [INST_WIDTH-1:0] Id_Inst1,
   output logic [2:0]            Buf_Count
);

   logic [ADDR_WIDTH-1:0] pc_r   [4];
   logic [INST_WIDTH-1:0] inst_r [4];
   logic [1:0]            rd_ptr_r;
   logic [1:0]            wr_ptr_r;
   logic [2:0]            count_r;

   logic                  ready_s;
   logic                  flush_s;
   logic [1:0]            valid_s;
   logic [1:0]            accept_s;
   logic [1:0]            take_s;
   logic [1:0]            enq_s;
   logic [1:0]            deq_s;
   logic [1:0]            rd_ptr1_s;
   logic [1:0]            wr_ptr1_s;
   logic                  unused_s;

   assign unused_s  = ^{Ctrl_Stall[4:2], Flush[3:1]};
   assign flush_s   = Flush[0] | EX_BranchFlag;
   // Readiness deliberately ignores any same-cycle dequeue
   assign ready_s   = (count_r <= 3'd2) & ~Ctrl_Stall[0];
   assign valid_s   = {(count_r >= 3'd2), (count_r >= 3'd1)};
   assign rd_ptr1_s = rd_ptr_r + 2'd1;
   assign wr_ptr1_s = wr_ptr_r + 2'd1;

   // Enqueue count from fetch valids; 10 is not a legal fetch pattern and enqueues nothing
   always_comb begin
      enq_s = 2'd0;
      if (ready_s) begin
         case (If_Valid)
            2'b01:   enq_s = 2'd1;
            2'b11:   enq_s = 2'd2;
            default: enq_s = 2'd0;
         endcase
      end else begin
         enq_s = 2'd0;
      end
   end

   // Dequeue count: accepted slots that actually hold an entry, unless ID is stalled
   always_comb begin
      accept_s = 2'b00;
      take_s   = 2'b00;
      deq_s    = 2'd0;
      if (Id_Accept == 2'b10) begin
         accept_s = 2'b00;
      end else begin
         accept_s = Id_Accept;
      end
      take_s = accept_s & valid_s;
      if (Ctrl_Stall[1]) begin
         deq_s = 2'd0;
      end else begin
         deq_s = {1'b0, take_s[0]} + {1'b0, take_s[1]};
      end
   end

   // Pointer and occupancy update; flush wins over stalls and discards this cycle's traffic
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= 2'd0;
         wr_ptr_r <= 2'd0;
         count_r  <= 3'd0;
      end else if (flush_s) begin
         rd_ptr_r <= 2'd0;
         wr_ptr_r <= 2'd0;
         count_r  <= 3'd0;
      end else begin
         rd_ptr_r <= rd_ptr_r + deq_s;
         wr_ptr_r <= wr_ptr_r + enq_s;
         count_r  <= count_r - {1'b0, deq_s} + {1'b0, enq_s};
      end
   end

   // Entry storage writes: slot0 at wr_ptr, slot1 at wr_ptr+1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            pc_r[i]   <= '0;
            inst_r[i] <= '0;
         end
      end else if (!flush_s) begin
         if (enq_s != 2'd0) begin
            pc_r[wr_ptr_r]   <= If_PC0;
            inst_r[wr_ptr_r] <= If_Inst0;
         end
         if (enq_s == 2'd2) begin
            pc_r[wr_ptr1_s]   <= If_PC1;
            inst_r[wr_ptr1_s] <= If_Inst1;
         end
      end
   end

   assign If_Ready  = ready_s;
   assign Id_Valid  = valid_s;
   assign Id_PC0    = pc_r[rd_ptr_r];
   assign Id_PC1    = pc_r[rd_ptr1_s];
   assign Id_Inst0  = inst_r[rd_ptr_r];
   assign Id_Inst1  = inst_r[rd_ptr1_s];
   assign Buf_Count = count_r;

   if_id_issue_buf_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .deq   (deq_s),
      .count (count_r)
   );

endmodule

// File: tb/tb_if_id_issue_buf.sv
// Directed self-checking bench for if_id_issue_buf with hand-computed expectations.

module tb_if_id_issue_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  If_Valid;
   logic [31:0] If_PC0, If_PC1, If_Inst0, If_Inst1;
   logic        If_Ready;
   logic [4:0]  Ctrl_Stall;
   logic [3:0]  Flush;
   logic        EX_BranchFlag;
   logic [1:0]  Id_Accept;
   logic [1:0]  Id_Valid;
   logic [31:0] Id_PC0, Id_PC1, Id_Inst0, Id_Inst1;
   logic [2:0]  Buf_Count;

   int n_cmp = 0;
   int n_err = 0;

   if_id_issue_buf #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .If_Valid(If_Valid), .If_PC0(If_PC0), .If_PC1(If_PC1),
      .If_Inst0(If_Inst0), .If_Inst1(If_Inst1), .If_Ready(If_Ready),
      .Ctrl_Stall(Ctrl_Stall), .Flush(Flush), .EX_BranchFlag(EX_BranchFlag),
      .Id_Accept(Id_Accept), .Id_Valid(Id_Valid),
      .Id_PC0(Id_PC0), .Id_PC1(Id_PC1), .Id_Inst0(Id_Inst0), .Id_Inst1(Id_Inst1),
      .Buf_Count(Buf_Count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
      If_Valid = v;
      If_PC0   = p0;
      If_PC1   = p1;
      If_Inst0 = inst_of(p0);
      If_Inst1 = inst_of(p1);
   endtask

   initial begin
      rst_n = 1'b0;
      fetch(2'b00, 32'h0, 32'h0);
      Ctrl_Stall = 5'b00000; Flush = 4'b0000; EX_BranchFlag = 1'b0; Id_Accept = 2'b00;
      repeat (3) tick();
      check("rst_valid", Id_Valid, 2'b00);
      check("rst_count", Buf_Count, 3'd0);
      check("rst_ready", If_Ready, 1'b1);
      check("rst_pc0", Id_PC0, 32'h0);
      check("rst_inst1", Id_Inst1, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // First pair, visible the cycle after enqueue
      fetch(2'b11, 32'h100, 32'h104);
      #1 check("pair_no_bypass", Id_Valid, 2'b00);
      tick();
      fetch(2'b00, 32'h0, 32'h0);
      check("pair_valid", Id_Valid, 2'b11);
      check("pair_pc0", Id_PC0, 32'h100);
      check("pair_pc1", Id_PC1, 32'h104);
      check("pair_inst0", Id_Inst0, 32'hC0DE0100);
      check("pair_count", Buf_Count, 3'd2);

      // Fill to 4, extra pair refused
      fetch(2'b11, 32'h108, 32'h10C);
      tick();
      check("fill_count4", Buf_Count, 3'd4);
      check("fill_ready4", If_Ready, 1'b0);
      fetch(2'b11, 32'h110, 32'h114);
      Id_Accept = 2'b01;
      tick();
      check("deq1_count3", Buf_Count, 3'd3);
      check("deq1_ready3", If_Ready, 1'b0);
      check("deq1_pc0", Id_PC0, 32'h104);
      check("deq1_pc1", Id_PC1, 32'h108);
      fetch(2'b00, 32'h0, 32'h0);
      Id_Accept = 2'b11;
      tick();
      check("drain_count1", Buf_Count, 3'd1);
      check("drain_pc0", Id_PC0, 32'h10C);
      check("drain_valid", Id_Valid, 2'b01);
      tick();
      check("drain_count0", Buf_Count, 3'd0);
      check("drain_valid0", Id_Valid, 2'b00);

      // Six single enqueue/dequeue pairs across pointer wrap
      for (int i = 0; i < 6; i++) begin
         Id_Accept = 2'b00;
         fetch(2'b01, 32'h200 + 32'(4 * i), 32'h0);
         tick();
         check("wrap_pc0", Id_PC0, 32'h200 + 32'(4 * i));
         check("wrap_valid", Id_Valid, 2'b01);
         fetch(2'b00, 32'h0, 32'h0);
         Id_Accept = 2'b01;
         tick();
         check("wrap_count", Buf_Count, 3'd0);
      end

      // Pair written across entries 3 and 0
      Id_Accept = 2'b00;
      fetch(2'b01, 32'h300, 32'h0);
      tick();
      fetch(2'b11, 32'h304, 32'h308);
      tick();
      check("pw_count", Buf_Count, 3'd3);
      check("pw_pc1", Id_PC1, 32'h304);
      fetch(2'b00, 32'h0, 32'h0);
      Id_Accept = 2'b01;
      tick();
      check("pw_pc0", Id_PC0, 32'h304);
      check("pw_pc1b", Id_PC1, 32'h308);
      check("pw_inst1", Id_Inst1, 32'hC0DE0308);

      // Simultaneous enq 2 / deq 2 at count 2
      fetch(2'b11, 32'h30C, 32'h310);
      Id_Accept = 2'b11;
      tick();
      check("swap_count", Buf_Count, 3'd2);
      check("swap_pc0", Id_PC0, 32'h30C);
      check("swap_pc1", Id_PC1, 32'h310);

      // Hazard stall freezes contents
      Ctrl_Stall = 5'b00011;
      fetch(2'b11, 32'h400, 32'h404);
      Id_Accept = 2'b11;
      #1 check("hz_ready", If_Ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hz_count", Buf_Count, 3'd2);
         check("hz_pc0", Id_PC0, 32'h30C);
         check("hz_pc1", Id_PC1, 32'h310);
         check("hz_ready_hold", If_Ready, 1'b0);
      end

      // Icache stall: enqueue blocked, decode drains
      Ctrl_Stall = 5'b00001;
      #1 check("ic_ready_pre", If_Ready, 1'b0);
      tick();
      check("ic_count0", Buf_Count, 3'd0);
      check("ic_ready", If_Ready, 1'b0);
      tick();
      check("ic_count_hold", Buf_Count, 3'd0);
      Ctrl_Stall = 5'b11100;
      fetch(2'b00, 32'h0, 32'h0);
      Id_Accept = 2'b00;
      #1 check("stall_hi_ignored", If_Ready, 1'b1);

      // Branch flush at count 3 with simultaneous fetch and accept
      fetch(2'b11, 32'h500, 32'h504);
      tick();
      fetch(2'b01, 32'h508, 32'h0);
      tick();
      check("fl_count3", Buf_Count, 3'd3);
      check("fl_ready3", If_Ready, 1'b0);
      fetch(2'b11, 32'h600, 32'h604);
      Id_Accept = 2'b01;
      EX_BranchFlag = 1'b1;
      tick();
      EX_BranchFlag = 1'b0;
      Id_Accept = 2'b00;
      check("fl_valid", Id_Valid, 2'b00);
      check("fl_count", Buf_Count, 3'd0);
      check("fl_ready", If_Ready, 1'b1);
      fetch(2'b01, 32'h800, 32'h0);
      tick();
      check("fl_refetch_pc0", Id_PC0, 32'h800);
      check("fl_refetch_cnt", Buf_Count, 3'd1);

      // Flush[0] beats hazard stall
      Ctrl_Stall = 5'b00011;
      Flush = 4'b0001;
      fetch(2'b01, 32'h900, 32'h0);
      tick();
      check("flush0_count", Buf_Count, 3'd0);
      Ctrl_Stall = 5'b00000;

      // Ignored flush bits, illegal 10 fetch and accept patterns
      Flush = 4'b1110;
      fetch(2'b01, 32'hA00, 32'h0);
      tick();
      check("flush_hi_ignored", Buf_Count, 3'd1);
      Flush = 4'b0000;
      fetch(2'b10, 32'hB00, 32'hB04);
      tick();
      check("ifv10_count", Buf_Count, 3'd1);
      fetch(2'b00, 32'h0, 32'h0);
      Id_Accept = 2'b10;
      tick();
      check("acc10_count", Buf_Count, 3'd1);
      check("acc10_pc0", Id_PC0, 32'hA00);
      Id_Accept = 2'b11;
      fetch(2'b01, 32'hC00, 32'h0);
      tick();
      check("acc11_one_valid", Buf_Count, 3'd1);
      check("acc11_pc0", Id_PC0, 32'hC00);
      Id_Accept = 2'b00;

      // Asynchronous reset mid-operation
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_count", Buf_Count, 3'd0);
      check("async_rst_valid", Id_Valid, 2'b00);
      check("async_rst_pc0", Id_PC0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_id_issue_buf.md
# if_id_issue_buf

Dual-issue fetch-to-decode instruction buffer between the IF stage and the two decode slots. It accepts up to two fetched instructions per cycle and holds them in a 4-entry circular queue. It presents the two oldest entries to decode slot 0 and slot 1, and retires up to two per cycle. It is the consumer of the pipeline controller's stall vector and IF/ID flush: it honours `Ctrl_Stall[0]`, `Ctrl_Stall[1]`, `Flush[0]` and `EX_BranchFlag`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC width.
- `INST_WIDTH`, 32, instruction word width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `If_Valid`  in  2  fetch slot valids; legal values are 00, 01 and 11; 10 is treated as 00.
- `If_PC0`, `If_PC1`  in  ADDR_WIDTH  fetch slot PCs.
- `If_Inst0`, `If_Inst1`  in  INST_WIDTH  fetch slot instruction words.
- `If_Ready`  out  1  buffer can take a full fetch pair this cycle.
- `Ctrl_Stall`  in  5  controller stall vector; bit0 stalls IF, bit1 stalls ID; bits 4:2 are ignored.
- `Flush`  in  4  controller flush vector; bit0 flushes IF/ID; bits 3:1 are ignored.
- `EX_BranchFlag`  in  1  redirect from EX; flushes like `Flush[0]`.
- `Id_Accept`  in  2  decode consumes slot0 / both; legal values are 00, 01 and 11.
- `Id_Valid`  out  2  bit0 means head entry valid; bit1 means head+1 valid.
- `Id_PC0`, `Id_PC1`  out  ADDR_WIDTH  PCs of head and head+1.
- `Id_Inst0`, `Id_Inst1`  out  INST_WIDTH  instruction words of head and head+1.
- `Buf_Count`  out  3  occupancy, 0..4.

## Operation
- State:
  - 4 entries of {PC, inst}.
  - 2-bit `rd_ptr` and `wr_ptr`; both wrap modulo 4.
  - 3-bit `count`.
- Reset clears pointers, `count` and every entry to 0. Outputs under reset: `Id_Valid`=00, all `Id_PC*`/`Id_Inst*`=0, `Buf_Count`=0, `If_Ready`=1.
- `If_Ready` = (`count` <= 2) & ~`Ctrl_Stall[0]`.
  - It uses the current `count` only and does not credit a same-cycle dequeue.
- Enqueue number `enq`:
  - `enq` = 0 if `If_Ready`=0 or `If_Valid` is 00 or 10.
  - Otherwise `enq` = 1 for 01 and 2 for 11.
  - Slot0 is written at `wr_ptr` and slot1 at `wr_ptr+1`.
- Dequeue number `deq`:
  - `deq` = 0 if `Ctrl_Stall[1]`=1.
  - Otherwise `deq` = popcount(`Id_Accept` & `Id_Valid`), with a value of 10 treated as 0.
- Outputs are combinational reads of storage:
  - `Id_Valid` = {`count`>=2, `count`>=1}.
  - Slot0 shows entry `rd_ptr`; slot1 shows entry `rd_ptr+1`.
  - Data of an invalid slot is don't-care.
- Update when there is no flush:
  - `rd_ptr` += `deq`.
  - `wr_ptr` += `enq`.
  - `count` = `count` - `deq` + `enq`.
- Flush: when `Flush[0]` | `EX_BranchFlag`:
  - `rd_ptr`, `wr_ptr` and `count` go to 0.
  - The same-cycle enqueue and dequeue are discarded.
  - Flush has priority over both stalls.
- Stall interaction:
  - `Ctrl_Stall` = 00011 (hazard) blocks both enqueue and dequeue, so contents are frozen.
  - `Ctrl_Stall` = 00001 (icache) blocks enqueue only; decode may keep draining.
- Invariant: `count` never exceeds 4 and never underflows. An assertion fires if `deq` > `count`.

## Timing
- Latency: an instruction enqueued at edge N appears on `Id_Valid` in the cycle after N. There is no same-cycle bypass.
- Enqueue and dequeue in the same cycle are allowed. At `count`=2 with `deq`=2 and `enq`=2, the next `count` is 2.
- Wrap-around: with `wr_ptr`=3 and `enq`=2, entries 3 and 0 are written and `wr_ptr` becomes 1.
- Full: at `count`=3 or 4, `If_Ready`=0 even if decode drains 2 that cycle.
- Flush takes effect at the edge where it is sampled. `Id_Valid`=00 in the following cycle, and `If_Ready`=1 unless `Ctrl_Stall[0]` is set.
- Asserting reset mid-operation clears state immediately (asynchronously). Deassertion is synchronous to `clk` through the system reset synchroniser.

## Test plan
- Reset, then `If_Valid`=11 with PCs 0x100/0x104 for one cycle and `Id_Accept`=00. Next cycle requires `Id_Valid`=11, `Id_PC0`=0x100, `Id_PC1`=0x104, `Buf_Count`=2.
- Fill to 4 with two pairs, holding `Id_Accept`=00. Requires `If_Ready`=0 at `count`=3/4. Then `Id_Accept`=01 for one cycle: `count` goes 4→3 and `Id_PC0` advances to 0x104.
- Wrap: cycle through 6 single-entry enqueue/dequeue pairs. `Id_PC0` tracks each PC in order (0x200, 0x204, …, 0x214) with no loss across pointer wrap at 3→0.
- `Ctrl_Stall`=00011 for 3 cycles with `If_Valid`=11 and `Id_Accept`=11. `Buf_Count` and `Id_PC0`/`Id_PC1` stay unchanged for all 3 cycles. `If_Ready`=0.
- `Ctrl_Stall`=00001 with `Id_Accept`=11 at `count`=2. Buffer drains to 0 and `If_Ready`=0 throughout.
- `EX_BranchFlag`=1 at `count`=3 with a simultaneous `If_Valid`=11 and `Id_Accept`=01. Next cycle `Id_Valid`=00 and `Buf_Count`=0, and a subsequent fetch of PC 0x800 appears at `Id_PC0`.
